conv_line_buffer: RTL and testbench

Three-row sliding line buffer that sources the column stream for the 3x3 convolution engine. It accepts raster-order pixels on a valid/ready write port and stores them in four row slots (three readable, one filling). It presents one vertically aligned column (top, middle, bottom pixel) per `shift_buffer` pulse from the convolver. At the end of each row pass it retires `stride` rows, so the next pass starts `stride` rows lower.

---
 rtl/conv_line_buffer.sv | 139 +++++++++++++
 tb/tb_conv_line_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_line_buffer.sv
// Three-row sliding line buffer: raster pixels fill four row slots, and the
// convolver pulls one vertically aligned column (top/middle/bottom) per shift.
module conv_line_buffer #(
  parameter int BIT_DEPTH = 8,
  parameter int IMG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [BIT_DEPTH-1:0] in_data,
  output logic                 in_ready,
  input  logic [1:0]           stride,
  input  logic                 shift_buffer,
  output logic                 out_valid,
  output logic [BIT_DEPTH-1:0] out_l1,
  output logic [BIT_DEPTH-1:0] out_l2,
  output logic [BIT_DEPTH-1:0] out_l3,
  output logic                 row_last
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  typedef enum logic {WAIT, STREAM} state_t;

  state_t state_reg, state_next;

  logic [BIT_DEPTH-1:0] mem [0:3][0:IMG_WIDTH-1];

  logic [1:0]       wr_slot_reg, wr_slot_next;
  logic [COL_W-1:0] wr_col_reg,  wr_col_next;
  logic [1:0]       rd_slot_reg, rd_slot_next;
  logic [COL_W-1:0] rd_col_reg,  rd_col_next;
  logic [2:0]       rows_full_reg, rows_full_next;

  logic       wr_fire;
  logic       row_done;
  logic       shift_fire;
  logic       pass_end;
  logic [1:0] eff_stride;

  assign in_ready   = (rows_full_reg != 3'd4);
  assign out_valid  = (state_reg == STREAM);
  assign row_last   = out_valid && (rd_col_reg == LAST_COL);
  assign wr_fire    = in_valid && in_ready && !flush;
  assign row_done   = wr_fire && (wr_col_reg == LAST_COL);
  assign shift_fire = out_valid && shift_buffer && !flush;
  assign pass_end   = shift_fire && (rd_col_reg == LAST_COL);

  always_comb begin
    case (stride)
      2'd2, 2'd3: eff_stride = 2'd2;
      default:    eff_stride = 2'd1;
    endcase
  end

  // Pointer and occupancy update; a row completing on the same edge as a
  // pass end nets out before the FSM looks at occupancy.
  always_comb begin
    wr_slot_next   = wr_slot_reg;
    wr_col_next    = wr_col_reg;
    rd_slot_next   = rd_slot_reg;
    rd_col_next    = rd_col_reg;
    rows_full_next = rows_full_reg;
    if (wr_fire) begin
      if (row_done) begin
        wr_col_next    = '0;
        wr_slot_next   = wr_slot_reg + 2'd1;
        rows_full_next = rows_full_next + 3'd1;
      end else begin
        wr_col_next = wr_col_reg + COL_W'(1);
      end
    end
    if (shift_fire) begin
      if (pass_end) begin
        rd_col_next    = '0;
        rd_slot_next   = rd_slot_reg + eff_stride;
        rows_full_next = rows_full_next - {1'b0, eff_stride};
      end else begin
        rd_col_next = rd_col_reg + COL_W'(1);
      end
    end
    if (flush) begin
      wr_slot_next   = '0;
      wr_col_next    = '0;
      rd_slot_next   = '0;
      rd_col_next    = '0;
      rows_full_next = '0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT:    if (rows_full_next >= 3'd3) state_next = STREAM;
      STREAM:  if (pass_end && rows_full_next < 3'd3) state_next = WAIT;
      default: state_next = WAIT;
    endcase
    if (flush) state_next = WAIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= WAIT;
      wr_slot_reg   <= '0;
      wr_col_reg    <= '0;
      rd_slot_reg   <= '0;
      rd_col_reg    <= '0;
      rows_full_reg <= '0;
    end else begin
      state_reg     <= state_next;
      wr_slot_reg   <= wr_slot_next;
      wr_col_reg    <= wr_col_next;
      rd_slot_reg   <= rd_slot_next;
      rd_col_reg    <= rd_col_next;
      rows_full_reg <= rows_full_next;
    end
  end

  // Row storage carries no reset: stale pixels are never visible because the
  // outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_slot_reg][wr_col_reg] <= in_data;
  end

  logic [1:0]           tap_slot [0:2];
  logic [BIT_DEPTH-1:0] tap      [0:2];

  for (genvar gi = 0; gi < 3; gi++) begin : g_tap
    assign tap_slot[gi] = rd_slot_reg + 2'(gi);
    assign tap[gi]      = out_valid ? mem[tap_slot[gi]][rd_col_reg] : '0;
  end

  assign out_l1 = tap[0];
  assign out_l2 = tap[1];
  assign out_l3 = tap[2];

endmodule

// File: tb/tb_conv_line_buffer.sv
// Scoreboard bench for conv_line_buffer at IMG_WIDTH=4: expected columns are
// derived from raster pixel numbering and compared as the DUT streams them.
module tb_conv_line_buffer;

  localparam int BD = 8;
  localparam int W  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [BD-1:0] in_data = '0;
  logic          in_ready;
  logic [1:0]    stride = 2'd1;
  logic          shift_buffer = 1'b0;
  logic          out_valid;
  logic [BD-1:0] out_l1, out_l2, out_l3;
  logic          row_last;

  conv_line_buffer #(.BIT_DEPTH(BD), .IMG_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stride(stride), .shift_buffer(shift_buffer),
    .out_valid(out_valid), .out_l1(out_l1), .out_l2(out_l2), .out_l3(out_l3),
    .row_last(row_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int l1;
    int l2;
    int l3;
    int last;
  } col_t;

  col_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Pixel numbering: pixel value = base + row*W + col + 1.
  task automatic push_pass(input int base, input int top);
    for (int c = 0; c < W; c++) begin
      col_t e;
      e.l1   = base + top * W + c + 1;
      e.l2   = base + (top + 1) * W + c + 1;
      e.l3   = base + (top + 2) * W + c + 1;
      e.last = (c == W - 1) ? 1 : 0;
      sb.push_back(e);
    end
  endtask

  task automatic write_px(input int v);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = BD'(v);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("wr_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Walks one pass; optionally lands a write of px on the final shift edge.
  task automatic run_pass(input int px);
    for (int c = 0; c < W; c++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        check("sb_empty", 0, 1);
      end else begin
        col_t e;
        e = sb.pop_front();
        check($sformatf("col%0d_valid", c), int'(out_valid), 1);
        check($sformatf("col%0d_l1", c), int'(out_l1), e.l1);
        check($sformatf("col%0d_l2", c), int'(out_l2), e.l2);
        check($sformatf("col%0d_l3", c), int'(out_l3), e.l3);
        check($sformatf("col%0d_last", c), int'(row_last), e.last);
      end
      shift_buffer = 1'b1;
      if (c == W - 1 && px != 0) begin
        check("sim_in_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = BD'(px);
      end
      @(posedge clk);
      #1;
      shift_buffer = 1'b0;
      in_valid     = 1'b0;
    end
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_l1", int'(out_l1), 0);
    check("rst_row_last", int'(row_last), 0);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      shift_buffer = 1'b1;
      @(posedge clk);
      #1;
      shift_buffer = 1'b0;
    end
    @(negedge clk);
    check("idle_out_valid", int'(out_valid), 0);
    check("idle_in_ready", int'(in_ready), 1);
    check("idle_out_l3", int'(out_l3), 0);

    // Fill three rows; out_valid must rise right after pixel 12's edge
    for (int p = 1; p <= 11; p++) write_px(p);
    check("fill11_out_valid", int'(out_valid), 0);
    write_px(12);
    check("fill12_out_valid", int'(out_valid), 1);

    // Fourth row fills the buffer, then backpressure
    for (int p = 13; p <= 16; p++) write_px(p);
    check("full_in_ready", int'(in_ready), 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd99;
    repeat (3) @(negedge clk);
    check("full_still_blocked", int'(in_ready), 0);
    in_valid = 1'b0;

    // Stride 1 pass over rows 0..2
    stride = 2'd1;
    push_pass(0, 0);
    run_pass(0);
    check("s1_in_ready", int'(in_ready), 1);
    check("s1_out_valid", int'(out_valid), 1);

    // Rows 1..3; row 4 completes on the same edge as the pass end
    for (int p = 17; p <= 19; p++) write_px(p);
    push_pass(0, 1);
    run_pass(20);
    check("sim_out_valid", int'(out_valid), 1);

    // Rows 2..4 with row 5 also resident; stride code 3 retires two rows
    for (int p = 21; p <= 24; p++) write_px(p);
    stride = 2'd3;
    push_pass(0, 2);
    run_pass(0);
    @(negedge clk);
    check("s2_out_valid", int'(out_valid), 0);
    check("s2_out_l2", int'(out_l2), 0);
    check("s2_in_ready", int'(in_ready), 1);
    for (int p = 25; p <= 27; p++) write_px(p);
    check("s2_wait_valid", int'(out_valid), 0);
    write_px(28);
    check("s2_resume_valid", int'(out_valid), 1);
    stride = 2'd0;
    push_pass(0, 4);
    run_pass(0);
    @(negedge clk);
    check("s0_out_valid", int'(out_valid), 0);

    // Flush with a pixel offered: pixel dropped, pointers reset
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd77;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", int'(out_valid), 0);
    check("flush_in_ready", int'(in_ready), 1);
    for (int p = 101; p <= 111; p++) write_px(p);
    check("flush11_out_valid", int'(out_valid), 0);
    write_px(112);
    check("flush12_out_valid", int'(out_valid), 1);
    stride = 2'd1;
    push_pass(100, 0);
    run_pass(0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
